// File: rtl/ysyx_23060229_lsu_pkg.sv
// Shared LSU types: FSM encoding and funct3 access-width decode.
// Misalignment checking is enabled by YSYX_23060229_LSU_MISALIGN_EN.
package ysyx_23060229_lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    W_BYTE,
    W_HALF,
    W_WORD
  } width_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic width_t ld_width(input logic [2:0] f);
    case (f)
      F3_B, F3_BU: ld_width = W_BYTE;
      F3_H, F3_HU: ld_width = W_HALF;
      default:     ld_width = W_WORD;
    endcase
  endfunction

  function automatic width_t st_width(input logic [2:0] f);
    case (f)
      F3_B:    st_width = W_BYTE;
      F3_H:    st_width = W_HALF;
      default: st_width = W_WORD;
    endcase
  endfunction

  function automatic logic misaligned(
    input width_t     w,
    input logic [1:0] off
  );
    case (w)
      W_HALF:  misaligned = off[0];
      W_WORD:  misaligned = |off;
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060229_lsu_align.sv
// Store lane shift/byte mask and load shift/extend, purely combinational.
// Bytes shifted past the aligned word are dropped in both directions.
module ysyx_23060229_lsu_align
  import ysyx_23060229_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            off,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rword,
  output logic [DATA_WIDTH-1:0] st_data,
  output logic [7:0]            st_mask,
  output logic [DATA_WIDTH-1:0] ld_data
);

  logic [4:0]            sh;
  logic [DATA_WIDTH-1:0] lw;
  logic [3:0]            m;
  logic                  sx;

  assign sh = {off, 3'b000};

  always_comb begin
    st_data = wdata << sh;
    lw      = rword >> sh;
    sx      = ~funct3[2];
    m       = 4'b1111;
    ld_data = lw;
    unique case (st_width(funct3))
      W_BYTE:  m = 4'b0001 << off;
      W_HALF:  m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    unique case (ld_width(funct3))
      W_BYTE:  ld_data = {{(DATA_WIDTH-8){sx & lw[7]}}, lw[7:0]};
      W_HALF:  ld_data = {{(DATA_WIDTH-16){sx & lw[15]}}, lw[15:0]};
      default: ld_data = lw;
    endcase
    st_mask = {4'b0000, m};
  end

endmodule

// File: rtl/ysyx_23060229_lsu.sv
// Load/store unit: one op at a time, emulated memory latency.
// Define YSYX_23060229_LSU_MISALIGN_EN to trap misaligned accesses.
module ysyx_23060229_lsu
  import ysyx_23060229_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_ren,
  input  logic                  in_wen,
  input  logic [2:0]            in_funct3,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rdata,
  output logic                  out_err,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [7:0]            mem_wmask
);

  state_t                state, state_nxt;
  logic                  ren_q, wen_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rword_q;
  logic [3:0]            cnt_q;
  logic                  acc_mis, fault;
  logic [DATA_WIDTH-1:0] st_data, ld_data;
  logic [7:0]            st_mask;
  logic                  req_rd, req_wr;
  logic [ADDR_WIDTH-1:0] waddr;

`ifdef YSYX_23060229_LSU_MISALIGN_EN
  logic err_q;
  width_t in_w;

  assign in_w    = in_wen ? st_width(in_funct3)
                          : ld_width(in_funct3);
  assign acc_mis = (in_ren | in_wen) & misaligned(in_w, in_addr[1:0]);
  assign fault   = err_q;

  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (state == S_IDLE && in_valid)
      err_q <= acc_mis;
  end
`else
  assign acc_mis = 1'b0;
  assign fault   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (in_valid) begin
          if (acc_mis || !(in_ren || in_wen))
            state_nxt = S_RESP;
          else
            state_nxt = S_REQ;
        end
      S_REQ:
        state_nxt = (LATENCY > 0) ? S_WAIT : S_RESP;
      S_WAIT:
        if (cnt_q <= 4'd1) state_nxt = S_RESP;
      S_RESP:
        if (out_ready) state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rword_q <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state)
        S_IDLE:
          if (in_valid) begin
            wen_q   <= in_wen;
            ren_q   <= in_ren & ~in_wen;
            f3_q    <= in_funct3;
            addr_q  <= in_addr;
            wdata_q <= in_wdata;
            rword_q <= '0;
          end
        S_REQ: begin
          if (ren_q) rword_q <= mem_rdata;
          cnt_q <= 4'(LATENCY);
        end
        S_WAIT:
          cnt_q <= cnt_q - 4'd1;
        default: ;
      endcase
    end
  end

  ysyx_23060229_lsu_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .funct3 (f3_q),
    .off    (addr_q[1:0]),
    .wdata  (wdata_q),
    .rword  (rword_q),
    .st_data(st_data),
    .st_mask(st_mask),
    .ld_data(ld_data)
  );

  assign req_rd = (state == S_REQ) & ren_q;
  assign req_wr = (state == S_REQ) & wen_q;
  assign waddr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_RESP);
  assign out_rdata = (out_valid && ren_q && !fault) ? ld_data : '0;
  assign out_err   = out_valid & fault;

  assign mem_ren   = req_rd;
  assign mem_raddr = req_rd ? waddr : '0;
  assign mem_wen   = req_wr;
  assign mem_waddr = req_wr ? waddr : '0;
  assign mem_wdata = req_wr ? st_data : '0;
  assign mem_wmask = req_wr ? st_mask : 8'h00;

endmodule

// File: doc/ysyx_23060229_lsu.md
# ysyx_23060229_lsu

Load/store unit that initiates all data accesses to `ysyx_23060229_Memory`. It accepts one memory operation at a time from the execute stage over a valid/ready handshake and drives the memory's read/write port. It aligns and masks store data, and extracts and extends load data. It returns the result to writeback over a second valid/ready handshake. A programmable wait count emulates memory latency so that pipeline stall logic is exercised before a real bus exists.

## Interface
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data word width; only 32 is supported.
- `LATENCY`, 0, extra wait cycles between the memory request and the response; legal range 0..15.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  execute stage presents an operation.
- `in_ready`  out  1  LSU can accept; high only in IDLE.
- `in_ren`  in  1  operation is a load.
- `in_wen`  in  1  operation is a store; takes priority over `in_ren`.
- `in_funct3`  in  3  RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `in_addr`  in  ADDR_WIDTH  byte address.
- `in_wdata`  in  DATA_WIDTH  store data, right-justified.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  writeback accepts the result.
- `out_rdata`  out  DATA_WIDTH  extended load data; 0 for stores and no-ops.
- `out_err`  out  1  misaligned access; present only with the macro, tied 0 otherwise.
- `mem_ren`  out  1  memory read enable.
- `mem_raddr`  out  ADDR_WIDTH  word-aligned read address.
- `mem_rdata`  in  DATA_WIDTH  combinational memory read data.
- `mem_wen`  out  1  memory write enable.
- `mem_waddr`  out  ADDR_WIDTH  word-aligned write address.
- `mem_wdata`  out  DATA_WIDTH  lane-shifted store data.
- `mem_wmask`  out  8  byte enables; bits [3:0] used, bits [7:4] always 0.

## Operation
- FSM states: IDLE → REQ → WAIT → RESP → IDLE.
- **IDLE**
  - `in_ready=1`.
  - On `in_valid`, latch the operation and go to REQ.
  - If neither `in_ren` nor `in_wen` is set, go directly to RESP with `out_rdata=0`.
- **REQ** (exactly one cycle)
  - Load: `mem_ren=1`, `mem_raddr = addr & ~3`, and `mem_rdata` is captured at the cycle's end.
  - Store: `mem_wen=1`, `mem_waddr = addr & ~3`, `mem_wdata = wdata << (8*addr[1:0])`.
  - Store mask: SB → `0001<<off`, SH → `0011<<off`, SW → `1111`, where `off = addr[1:0]`.
  - Go to WAIT if `LATENCY>0`, else RESP.
- **WAIT**: 4-bit counter loaded with `LATENCY` and decremented each cycle; go to RESP when it reaches 1.
- **RESP**
  - `out_valid=1`; the output is held stable until `out_ready`, then go to IDLE.
- **Load extraction**
  - Shift the captured word right by `8*off`.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
- **Unlisted funct3** is treated as word width.
- **Misaligned access without the macro**: the access uses the aligned word only.
  - Load bytes beyond byte 3 read as 0 before extension.
  - Store mask bits shifted past bit 3 are dropped.
- **Memory enables**: `mem_ren` and `mem_wen` are never high outside REQ and never high together.
- **Reset**
  - Reset at any point returns the FSM to IDLE.
  - It clears the latched operation, the counter and the captured data.
  - An in-flight response is discarded.
- **Reset values**: `in_ready=1`; `out_valid=0`, `out_rdata=0`, `out_err=0`; `mem_ren=0`, `mem_wen=0`; `mem_raddr=0`, `mem_waddr=0`, `mem_wdata=0`, `mem_wmask=0`.

## Timing
- Accept at edge 0; REQ during cycle 1; `out_valid` rises at cycle `2+LATENCY`.
- No-op path: `out_valid` at cycle 1.
- Minimum issue interval is `3+LATENCY` cycles, plus any cycles RESP waits on `out_ready`.
- `in_ready` drops in the cycle after acceptance; it is not combinationally dependent on `out_ready`.
- `mem_*` outputs are registered-state decodes with no path from `in_*` to `mem_*` inside a cycle.
- Store commit: memory writes at the edge ending REQ. If `rst` is high at that edge, the memory ignores the write.

## Configuration
- `YSYX_23060229_LSU_MISALIGN_EN` **defined**:
  - Alignment is checked in IDLE at acceptance: halfword requires `addr[0]=0`, word requires `addr[1:0]=0`.
  - A violating operation skips REQ/WAIT; no memory enable is asserted.
  - It goes to RESP with `out_err=1` and `out_rdata=0`.
- **Undefined**: no check; `out_err` is tied to 0; misaligned accesses behave as described in Operation.

## Structure
- Shared package / `macro.v`:
  - FSM state encoding.
  - funct3 width constants (BYTE/HALF/WORD, unsigned flag).
- One natural sub-module: `ysyx_23060229_lsu_align`, a combinational block holding the store shift/mask and load shift/extend logic. It is reused later by a cache.

## Test plan
- SW `0xDEADBEEF` @ `0x80000004`, `LATENCY=0` → REQ has `mem_wen=1`, `waddr=0x80000004`, `wmask=0x0F`; `out_valid` at cycle 2 with rdata 0.
- SB `0x000000A5` @ `0x80000007` → `wmask=0x08`, `wdata=0xA5000000`; a subsequent LBU @ `0x80000007` returns `0x000000A5`, LB returns `0xFFFFFFA5`.
- LH @ `0x80000002` on word `0x8001_1234` → `out_rdata=0xFFFF8001`; LHU → `0x00008001`.
- `LATENCY=3`, `out_ready` held low 2 cycles → `out_valid` at cycle 5, data stable until handshake, `in_ready` low throughout.
- `rst` asserted during WAIT → next cycle IDLE, `out_valid=0`, `in_ready=1`, no further `mem_ren`/`mem_wen`.
- Macro defined, LW @ `0x80000002` → no memory enable; `out_valid=1`, `out_err=1` at cycle 1.
